wash_seq_ctrl: RTL and testbench

Program sequencer for the washing-machine controller. Accepts a start command and steps the machine through fill, wash, drain, rinse and spin phases. Drives the water valves, the motor direction code and the door lock. Phase durations are counted in whole seconds, derived from the system clock by an internal prescaler, and the block reports completion on an active-low `compl_n` line.

---
 rtl/wash_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_wash_seq_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wash_seq_ctrl.sv
// Washing-machine program sequencer: fill, wash, drain, rinse x N, spin.
// Phase timing in whole seconds from an internal prescaler; registered outputs.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start                begin a program (accepted in IDLE or DONE)
//   pause                freeze timers and actuators while high
//   level_full/empty     drum level sensors
//   motor[1:0]           00 stop, 01 fwd, 10 rev, 11 spin
//   valve_in/valve_out   fill / drain valves
//   door_lock, busy      door locked, program running
//   compl_n              low from program end until next start
//   err                  sticky fault (fill/drain timeout)

module wash_seq_ctrl #(
   parameter int FREQ       = 40_000,
   parameter int WASH_S     = 600,
   parameter int RINSE_S    = 300,
   parameter int RINSES     = 2,
   parameter int SPIN_S     = 300,
   parameter int DIR_S      = 10,
   parameter int FILL_TO_S  = 120,
   parameter int DRAIN_TO_S = 120
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       pause,
   input  logic       level_full,
   input  logic       level_empty,
   output logic [1:0] motor,
   output logic       valve_in,
   output logic       valve_out,
   output logic       door_lock,
   output logic       busy,
   output logic       compl_n,
   output logic       err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_WASH,
      S_DRAIN,
      S_RINSE,
      S_SPIN,
      S_DONE,
      S_ERROR
   } state_t;

   localparam int PW = (FREQ > 1) ? $clog2(FREQ) : 1;

   localparam logic [PW-1:0] PRE_TC   = PW'(FREQ - 1);
   localparam logic [15:0]   WASH_TC  = 16'(WASH_S - 1);
   localparam logic [15:0]   RINSE_TC = 16'(RINSE_S - 1);
   localparam logic [15:0]   SPIN_TC  = 16'(SPIN_S - 1);
   localparam logic [15:0]   DIR_TC   = 16'(DIR_S - 1);
   localparam logic [15:0]   FILL_TC  = 16'(FILL_TO_S - 1);
   localparam logic [15:0]   DRAIN_TC = 16'(DRAIN_TO_S - 1);

   state_t          state_q, state_d;
   logic [3:0]      rinse_q, rinse_d;
   logic            phr_q, phr_d;
   logic [PW-1:0]   pre_q, pre_d;
   logic [15:0]     sec_q, sec_d;
   logic [15:0]     dcnt_q, dcnt_d;
   logic            dir_q, dir_d;
   logic [1:0]      motor_q, motor_d;
   logic            vin_q, vin_d;
   logic            vout_q, vout_d;
   logic            lock_q, lock_d;
   logic            busy_q, busy_d;
   logic            compl_n_q, compl_n_d;
   logic            err_q, err_d;

   logic running;
   logic hold;
   logic tick;
   logic entry;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         rinse_q   <= '0;
         phr_q     <= 1'b0;
         pre_q     <= '0;
         sec_q     <= '0;
         dcnt_q    <= '0;
         dir_q     <= 1'b0;
         motor_q   <= 2'b00;
         vin_q     <= 1'b0;
         vout_q    <= 1'b0;
         lock_q    <= 1'b0;
         busy_q    <= 1'b0;
         compl_n_q <= 1'b1;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rinse_q   <= rinse_d;
         phr_q     <= phr_d;
         pre_q     <= pre_d;
         sec_q     <= sec_d;
         dcnt_q    <= dcnt_d;
         dir_q     <= dir_d;
         motor_q   <= motor_d;
         vin_q     <= vin_d;
         vout_q    <= vout_d;
         lock_q    <= lock_d;
         busy_q    <= busy_d;
         compl_n_q <= compl_n_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      running = state_q inside {S_FILL, S_WASH, S_DRAIN, S_RINSE, S_SPIN};
      hold    = running & pause;
      tick    = running & ~pause & (pre_q == PRE_TC);

      state_d = state_q;
      rinse_d = rinse_q;
      phr_d   = phr_q;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_FILL;
               rinse_d = 4'(RINSES);
               phr_d   = 1'b0;
            end
         end
         S_FILL: begin
            // sensor outranks a timeout landing on the same edge
            if (!hold && level_full) begin
               if (phr_q) begin
                  state_d = S_RINSE;
                  rinse_d = rinse_q - 4'd1;
               end else begin
                  state_d = S_WASH;
               end
            end else if (tick && sec_q == FILL_TC) begin
               state_d = S_ERROR;
            end
         end
         S_WASH: begin
            if (tick && sec_q == WASH_TC) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (!hold && level_empty) begin
               if (rinse_q != 4'd0) begin
                  state_d = S_FILL;
                  phr_d   = 1'b1;
               end else begin
                  state_d = S_SPIN;
               end
            end else if (tick && sec_q == DRAIN_TC) begin
               state_d = S_ERROR;
            end
         end
         S_RINSE: begin
            if (tick && sec_q == RINSE_TC) state_d = S_DRAIN;
         end
         S_SPIN: begin
            if (tick && sec_q == SPIN_TC) state_d = S_DONE;
         end
         S_ERROR: begin
            state_d = S_ERROR;
         end
      endcase

      entry = (state_d != state_q);

      pre_d  = pre_q;
      sec_d  = sec_q;
      dcnt_d = dcnt_q;
      dir_d  = dir_q;

      // every phase starts with fresh timers and forward rotation
      if (entry) begin
         pre_d  = '0;
         sec_d  = '0;
         dcnt_d = '0;
         dir_d  = 1'b0;
      end else if (tick) begin
         pre_d = '0;
         sec_d = sec_q + 16'd1;
         if (dcnt_q == DIR_TC) begin
            dcnt_d = '0;
            dir_d  = ~dir_q;
         end else begin
            dcnt_d = dcnt_q + 16'd1;
         end
      end else if (running && !pause) begin
         pre_d = pre_q + PW'(1);
      end
   end

   // outputs follow the next state; hold only occurs with state_d == state_q
   always_comb begin
      motor_d   = 2'b00;
      vin_d     = 1'b0;
      vout_d    = 1'b0;
      compl_n_d = 1'b1;
      err_d     = 1'b0;
      lock_d    = !(state_d inside {S_IDLE, S_DONE});
      busy_d    = state_d inside {S_FILL, S_WASH, S_DRAIN, S_RINSE, S_SPIN};

      unique case (state_d)
         S_FILL: begin
            vin_d = ~hold;
         end
         S_WASH, S_RINSE: begin
            if (!hold) motor_d = dir_d ? 2'b10 : 2'b01;
         end
         S_DRAIN: begin
            vout_d = ~hold;
         end
         S_SPIN: begin
            if (!hold) begin
               motor_d = 2'b11;
               vout_d  = 1'b1;
            end
         end
         S_DONE: begin
            compl_n_d = 1'b0;
         end
         S_ERROR: begin
            err_d = 1'b1;
         end
         S_IDLE: begin
            motor_d = 2'b00;
         end
      endcase
   end

   assign motor     = motor_q;
   assign valve_in  = vin_q;
   assign valve_out = vout_q;
   assign door_lock = lock_q;
   assign busy      = busy_q;
   assign compl_n   = compl_n_q;
   assign err       = err_q;

endmodule

// File: tb/tb_wash_seq_ctrl.sv
// Testbench for wash_seq_ctrl: directed scenarios plus randomized programs
// compared cycle by cycle against a phase-list reference model.

module tb_wash_seq_ctrl;

   localparam int FREQ       = 4;
   localparam int WASH_S     = 3;
   localparam int RINSE_S    = 2;
   localparam int RINSES     = 1;
   localparam int SPIN_S     = 2;
   localparam int DIR_S      = 1;
   localparam int FILL_TO_S  = 5;
   localparam int DRAIN_TO_S = 5;

   localparam int K_F = 0;
   localparam int K_W = 1;
   localparam int K_D = 2;
   localparam int K_R = 3;
   localparam int K_S = 4;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;
   localparam int M_ERR  = 3;

   localparam logic [7:0] O_IDLE = 8'b00_0_0_0_0_1_0;
   localparam logic [7:0] O_DONE = 8'b00_0_0_0_0_0_0;
   localparam logic [7:0] O_ERR  = 8'b00_0_0_1_0_1_1;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       pause;
   logic       level_full;
   logic       level_empty;
   logic [1:0] motor;
   logic       valve_in;
   logic       valve_out;
   logic       door_lock;
   logic       busy;
   logic       compl_n;
   logic       err;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // reference model: list of phases, index, unpaused cycles in phase
   int m_mode;
   int m_ph[$];
   int m_pi;
   int m_el;
   bit m_hold;

   int fdly;
   int ddly;
   bit noise;

   always #5 clk = ~clk;

   wash_seq_ctrl #(
      .FREQ(FREQ), .WASH_S(WASH_S), .RINSE_S(RINSE_S),
      .RINSES(RINSES), .SPIN_S(SPIN_S), .DIR_S(DIR_S),
      .FILL_TO_S(FILL_TO_S), .DRAIN_TO_S(DRAIN_TO_S)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .pause(pause),
      .level_full(level_full), .level_empty(level_empty),
      .motor(motor), .valve_in(valve_in), .valve_out(valve_out),
      .door_lock(door_lock), .busy(busy), .compl_n(compl_n),
      .err(err)
   );

   function automatic void m_reset();
      m_mode = M_IDLE;
      m_ph.delete();
      m_pi   = 0;
      m_el   = 0;
      m_hold = 1'b0;
   endfunction

   function automatic void m_start();
      m_ph.delete();
      m_ph.push_back(K_F);
      m_ph.push_back(K_W);
      m_ph.push_back(K_D);
      for (int i = 0; i < RINSES; i++) begin
         m_ph.push_back(K_F);
         m_ph.push_back(K_R);
         m_ph.push_back(K_D);
      end
      m_ph.push_back(K_S);
      m_pi   = 0;
      m_el   = 0;
      m_mode = M_RUN;
   endfunction

   function automatic int m_kind();
      if (m_mode != M_RUN) return -1;
      return m_ph[m_pi];
   endfunction

   function automatic int limit(int k);
      case (k)
         K_W:     return WASH_S * FREQ;
         K_R:     return RINSE_S * FREQ;
         K_S:     return SPIN_S * FREQ;
         K_F:     return FILL_TO_S * FREQ;
         default: return DRAIN_TO_S * FREQ;
      endcase
   endfunction

   function automatic void m_step(input logic r, input logic s,
                                  input logic p, input logic lf,
                                  input logic le);
      int k;
      bit sens;
      m_hold = 1'b0;
      if (r) begin
         m_reset();
         return;
      end
      case (m_mode)
         M_IDLE, M_DONE: begin
            if (s) m_start();
         end
         M_RUN: begin
            if (p) begin
               m_hold = 1'b1;
            end else begin
               k    = m_ph[m_pi];
               sens = (k == K_F && lf) || (k == K_D && le);
               m_el++;
               if (sens || (m_el == limit(k) && k != K_F && k != K_D)) begin
                  m_pi++;
                  m_el = 0;
                  if (m_pi == m_ph.size()) m_mode = M_DONE;
               end else if (m_el == limit(k)) begin
                  m_mode = M_ERR;
               end
            end
         end
         default: ;
      endcase
   endfunction

   function automatic logic [7:0] m_outs();
      logic [1:0] mot;
      logic vi;
      logic vo;
      int k;
      mot = 2'b00;
      vi  = 1'b0;
      vo  = 1'b0;
      case (m_mode)
         M_IDLE: return O_IDLE;
         M_DONE: return O_DONE;
         M_ERR:  return O_ERR;
         default: ;
      endcase
      k = m_ph[m_pi];
      if (!m_hold) begin
         case (k)
            K_F: vi = 1'b1;
            K_D: vo = 1'b1;
            K_S: begin
               mot = 2'b11;
               vo  = 1'b1;
            end
            default: mot = ((m_el / (DIR_S * FREQ)) % 2 == 1) ? 2'b10 : 2'b01;
         endcase
      end
      return {mot, vi, vo, 1'b1, 1'b1, 1'b1, 1'b0};
   endfunction

   function automatic logic [7:0] dut_outs();
      return {motor, valve_in, valve_out, door_lock, busy, compl_n, err};
   endfunction

   task automatic check(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
      end
   endtask

   task automatic step(input bit s, input bit p);
      int k;
      start       = s;
      pause       = p;
      level_full  = noise ? 1'($urandom) : 1'b0;
      level_empty = noise ? 1'($urandom) : 1'b0;
      k = m_kind();
      if (k == K_F) level_full  = (m_el + 1 >= fdly);
      if (k == K_D) level_empty = (m_el + 1 >= ddly);
      @(posedge clk);
      m_step(rst, start, pause, level_full, level_empty);
      cyc++;
      @(negedge clk);
      check("outs", dut_outs(), m_outs());
   endtask

   task automatic run_prog(input int budget, input bit rnd);
      for (int n = 0; n < budget && m_mode == M_RUN; n++) begin
         if (rnd) step($urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0);
         else     step(1'b0, 1'b0);
      end
   endtask

   initial begin
      rst         = 1'b1;
      start       = 1'b0;
      pause       = 1'b0;
      level_full  = 1'b0;
      level_empty = 1'b0;
      noise       = 1'b0;
      fdly        = 3;
      ddly        = 3;
      m_reset();

      // reset held, then released with start low
      repeat (3) step(1'b0, 1'b0);
      check("reset", dut_outs(), O_IDLE);
      rst = 1'b0;
      repeat (3) step(1'b0, 1'b0);
      check("idle", dut_outs(), O_IDLE);

      // full program, sensors 3 cycles after each fill/drain entry
      step(1'b1, 1'b0);
      run_prog(100, 1'b0);
      check("done", dut_outs(), O_DONE);
      repeat (2) step(1'b0, 1'b0);

      // fill timeout; start from DONE, then start/pause ignored in ERROR
      fdly = 1000;
      step(1'b1, 1'b0);
      run_prog(40, 1'b0);
      check("fill_to", dut_outs(), O_ERR);
      repeat (3) step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      check("err_sticky", dut_outs(), O_ERR);
      rst = 1'b1;
      step(1'b0, 1'b0);
      rst = 1'b0;
      step(1'b0, 1'b0);

      // pause in wash, with a start pulse during wash
      fdly = 3;
      step(1'b1, 1'b0);
      for (int n = 0; n < 20 && m_kind() != K_W; n++) step(1'b0, 1'b0);
      repeat (3) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      repeat (10) step(1'b0, 1'b1);
      run_prog(100, 1'b0);
      check("pause_done", dut_outs(), O_DONE);

      // sensor on the timeout edge wins
      fdly = 20;
      ddly = 20;
      step(1'b1, 1'b0);
      run_prog(200, 1'b0);
      check("sens_wins", dut_outs(), O_DONE);

      // minimum dwell of one cycle
      fdly = 1;
      ddly = 1;
      step(1'b1, 1'b0);
      run_prog(100, 1'b0);
      check("min_dwell", dut_outs(), O_DONE);

      // asynchronous reset in the middle of spin
      fdly = 2;
      ddly = 2;
      step(1'b1, 1'b0);
      for (int n = 0; n < 100 && !(m_kind() == K_S && m_el == 3); n++)
         step(1'b0, 1'b0);
      check("pre_rst_spin", dut_outs(), 8'b11_0_1_1_1_1_0);
      #2 rst = 1'b1;
      #1 check("rst_spin", dut_outs(), O_IDLE);
      m_reset();
      step(1'b0, 1'b0);
      rst = 1'b0;
      repeat (2) step(1'b0, 1'b0);

      // randomized programs: sensor delays, noise, pauses, stray starts
      for (int r = 0; r < 16; r++) begin
         fdly  = $urandom_range(1, 22);
         ddly  = $urandom_range(1, 22);
         noise = 1'($urandom);
         step(1'b1, 1'($urandom));
         run_prog(600, 1'b1);
         if (m_mode == M_ERR) begin
            step(1'b1, 1'b0);
            rst = 1'b1;
            step(1'b0, 1'b0);
            rst = 1'b0;
         end
         step(1'b0, 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
